// File: rtl/rv32i_types.sv
// Shared RV32I encodings used by the memory pipeline stage and its helpers.
// Pure types/constants: no latency, no flow control.
// Stage FSM states are plain localparams so legacy code can compare against them.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t IDLE = 2'd0;
    localparam mem_state_t REQ  = 2'd1;
    localparam mem_state_t HOLD = 2'd2;

    // funct3[1:0] encodes the access width for both loads and stores
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load formatter: lane-shifts a memory word and sign/zero-extends per funct3.
// Purely combinational, zero latency.
// No flow control; unknown funct3 yields zero.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            lb:      data = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     data = {24'b0, shifted[7:0]};
            lh:      data = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     data = {16'b0, shifted[15:0]};
            lw:      data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory read/write, formats load data for MEM/WB.
// Latency: request in the access cycle, stalls until the resp pulse (best case 1 stall cycle).
// Backpressure: holds the pipe via mem_stall; a resp under ext_stall is parked in HOLD, never re-issued.
module mem_stage
    import rv32i_types::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_MEM,
    input  logic        mem_read_MEM,
    input  logic        mem_write_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] ALU_out_MEM,
    input  logic [31:0] rs2_MEM,
    input  logic        ext_stall,
    input  logic        data_mem_resp,
    input  logic [31:0] data_mem_rdata,
    output logic        data_mem_read,
    output logic        data_mem_write,
    output logic [31:0] data_mem_address,
    output logic [3:0]  data_mem_mbe,
    output logic [31:0] data_mem_wdata,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        misalign
);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic [31:0] rdata_q;

    logic [1:0]  off;
    logic [1:0]  size;
    logic        mem_op;
    logic        access;
    logic        req_active;
    logic        is_store;
    logic        load_done;
    logic [3:0]  mbe_raw;
    logic [31:0] src_word;
    logic [31:0] formatted;

    assign off    = ALU_out_MEM[1:0];
    assign size   = funct3_MEM[1:0];
    assign mem_op = valid_MEM & (mem_read_MEM | mem_write_MEM);

    assign misalign = ALIGN_CHECK & mem_op &
                      (((size == SIZE_HALF) & off[0]) | ((size == SIZE_WORD) & (off != 2'b00)));

    assign access     = mem_op & ~misalign;
    assign req_active = ((state_q == IDLE) & access) | (state_q == REQ);
    // read wins when both control bits are set
    assign is_store   = mem_write_MEM & ~mem_read_MEM;

    always_comb begin
        mbe_raw = 4'b1111;
        if (!mem_read_MEM) begin
            case (size)
                SIZE_BYTE: mbe_raw = 4'b0001 << off;
                SIZE_HALF: mbe_raw = 4'b0011 << off;
                default:   mbe_raw = 4'b1111;
            endcase
        end
    end

    assign data_mem_read    = mem_read_MEM & req_active;
    assign data_mem_write   = is_store & req_active;
    assign data_mem_address = req_active ? {ALU_out_MEM[31:2], 2'b00} : 32'b0;
    assign data_mem_mbe     = req_active ? mbe_raw : 4'b0;
    assign data_mem_wdata   = req_active ? (rs2_MEM << {off, 3'b000}) : 32'b0;

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = access;
                if (access) state_d = REQ;
            end
            REQ: begin
                mem_stall = ~data_mem_resp;
                if (data_mem_resp) state_d = ext_stall ? HOLD : IDLE;
            end
            HOLD: begin
                if (!ext_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == REQ) && data_mem_resp) rdata_q <= data_mem_rdata;
        end
    end

    assign load_done = mem_read_MEM & ~misalign &
                       (((state_q == REQ) & data_mem_resp) | (state_q == HOLD));
    assign src_word  = (state_q == HOLD) ? rdata_q : data_mem_rdata;

    load_align u_load_align (
        .word   (src_word),
        .off    (off),
        .funct3 (funct3_MEM),
        .data   (formatted)
    );

    assign load_data = load_done ? formatted : 32'b0;

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven plus randomized checks of mem_stage against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_MEM = 1'b0, valid_b = 1'b0;
    logic        mem_read_MEM = 1'b0, mem_write_MEM = 1'b0;
    logic [2:0]  funct3_MEM = 3'd0;
    logic [31:0] ALU_out_MEM = 32'd0, rs2_MEM = 32'd0, data_mem_rdata = 32'd0;
    logic        ext_stall = 1'b0, data_mem_resp = 1'b0;

    logic        rd_o, wr_o, stall_o, mis_o;
    logic [31:0] addr_o, wdata_o, load_o;
    logic [3:0]  mbe_o;
    logic        rd_b, wr_b, stall_b, mis_b;
    logic [31:0] addr_b, wdata_b, load_b;
    logic [3:0]  mbe_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_MEM(valid_MEM), .mem_read_MEM(mem_read_MEM),
        .mem_write_MEM(mem_write_MEM), .funct3_MEM(funct3_MEM), .ALU_out_MEM(ALU_out_MEM),
        .rs2_MEM(rs2_MEM), .ext_stall(ext_stall), .data_mem_resp(data_mem_resp),
        .data_mem_rdata(data_mem_rdata), .data_mem_read(rd_o), .data_mem_write(wr_o),
        .data_mem_address(addr_o), .data_mem_mbe(mbe_o), .data_mem_wdata(wdata_o),
        .load_data(load_o), .mem_stall(stall_o), .misalign(mis_o)
    );

    mem_stage #(.ALIGN_CHECK(1'b0)) dut_nochk (
        .clk(clk), .rst_n(rst_n), .valid_MEM(valid_b), .mem_read_MEM(mem_read_MEM),
        .mem_write_MEM(mem_write_MEM), .funct3_MEM(funct3_MEM), .ALU_out_MEM(ALU_out_MEM),
        .rs2_MEM(rs2_MEM), .ext_stall(ext_stall), .data_mem_resp(data_mem_resp),
        .data_mem_rdata(data_mem_rdata), .data_mem_read(rd_b), .data_mem_write(wr_b),
        .data_mem_address(addr_b), .data_mem_mbe(mbe_b), .data_mem_wdata(wdata_b),
        .load_data(load_b), .mem_stall(stall_b), .misalign(mis_b)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        int          delay;
        bit          ext;
        int          hold;
        logic [31:0] e_addr, e_wdata, e_load;
        logic [3:0]  e_mbe;
        bit          e_mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_rd, input logic e_wr, input logic e_stall,
                             input logic [31:0] e_addr, input logic [3:0] e_mbe,
                             input logic [31:0] e_wdata, input logic [31:0] e_load, input logic e_mis);
        chk({tag, ".read"},    {31'b0, rd_o},    {31'b0, e_rd});
        chk({tag, ".write"},   {31'b0, wr_o},    {31'b0, e_wr});
        chk({tag, ".stall"},   {31'b0, stall_o}, {31'b0, e_stall});
        chk({tag, ".address"}, addr_o,           e_addr);
        chk({tag, ".mbe"},     {28'b0, mbe_o},   {28'b0, e_mbe});
        chk({tag, ".wdata"},   wdata_o,          e_wdata);
        chk({tag, ".load"},    load_o,           e_load);
        chk({tag, ".misalign"},{31'b0, mis_o},   {31'b0, e_mis});
    endtask

    // Reference model: derives expected request/response values from address, width and data.
    function automatic vec_t model(input vec_t v);
        int unsigned off, sz, bv, hv;
        logic [31:0] sh;
        off = v.addr % 4;
        sz  = v.f3 % 4;
        v.e_mis   = (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
        v.e_addr  = v.addr - off;
        v.e_mbe   = v.rd ? 4'hF : (sz == 0 ? 4'(1 << off) : (sz == 1 ? 4'(3 << off) : 4'hF));
        v.e_wdata = 32'(v.rs2 * (32'd1 << (8 * off)));
        sh = v.rdata / (32'd1 << (8 * off));
        bv = sh % 256;
        hv = sh % 65536;
        case (v.f3)
            3'd0:    v.e_load = (bv >= 128) ? bv - 256 : bv;
            3'd1:    v.e_load = (hv >= 32768) ? hv - 65536 : hv;
            3'd2:    v.e_load = sh;
            3'd4:    v.e_load = bv;
            3'd5:    v.e_load = hv;
            default: v.e_load = 32'd0;
        endcase
        if (!v.rd) v.e_load = 32'd0;
        if (v.e_mis) begin
            v.e_addr = 0; v.e_mbe = 0; v.e_wdata = 0; v.e_load = 0;
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                                input int delay, input bit ext, input int hold,
                                input logic [31:0] e_addr, input logic [3:0] e_mbe,
                                input logic [31:0] e_wdata, input logic [31:0] e_load, input bit e_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.delay = delay; v.ext = ext; v.hold = hold;
        v.e_addr = e_addr; v.e_mbe = e_mbe; v.e_wdata = e_wdata; v.e_load = e_load; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        valid_MEM = 1'b0; data_mem_resp = 1'($urandom_range(0, 1)); ext_stall = 1'($urandom_range(0, 1));
        mem_read_MEM = 1'($urandom_range(0, 1)); mem_write_MEM = 1'($urandom_range(0, 1));
        data_mem_rdata = $urandom;
        #4 check_all("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic e_wr;
        e_wr = v.wr & ~v.rd;
        @(negedge clk);
        valid_MEM = 1'b1; mem_read_MEM = v.rd; mem_write_MEM = v.wr; funct3_MEM = v.f3;
        ALU_out_MEM = v.addr; rs2_MEM = v.rs2; data_mem_resp = 1'b0; ext_stall = 1'b0;
        data_mem_rdata = $urandom;
        if (v.e_mis) begin
            #4 check_all("misaligned", 0, 0, 0, 0, 0, 0, 0, 1);
            return;
        end
        for (int c = 0; c <= v.delay; c++) begin
            if (c > 0) @(negedge clk);
            data_mem_resp  = (c == v.delay);
            ext_stall      = (c == v.delay) ? v.ext : 1'($urandom_range(0, 1));
            data_mem_rdata = (c == v.delay) ? v.rdata : $urandom;
            #4 check_all("request", v.rd, e_wr, c != v.delay, v.e_addr, v.e_mbe, v.e_wdata,
                         (c == v.delay) ? v.e_load : 32'd0, 0);
        end
        if (v.ext) begin
            for (int h = 0; h <= v.hold; h++) begin
                @(negedge clk);
                data_mem_resp = 1'b0; data_mem_rdata = $urandom; ext_stall = (h < v.hold);
                #4 check_all("hold", 0, 0, 0, 0, 0, 0, v.e_load, 0);
            end
        end
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        tbl[0] = mk(1, 0, 3'd2, 32'h100, 32'h11111111, 32'hDEADBEEF, 3, 0, 0, 32'h100, 4'hF, 32'h11111111, 32'hDEADBEEF, 0);
        tbl[1] = mk(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80, 0);
        tbl[2] = mk(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 0, 32'h100, 4'hF, 32'h0, 32'h00000080, 0);
        tbl[3] = mk(0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h5555AAAA, 2, 0, 0, 32'h200, 4'hC, 32'hABCD0000, 32'h0, 0);
        tbl[4] = mk(1, 0, 3'd2, 32'h100, 32'h0, 32'h12345678, 1, 1, 2, 32'h100, 4'hF, 32'h0, 32'h12345678, 0);
        tbl[5] = mk(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tbl[6] = mk(0, 1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 1, 1, 0, 32'h200, 4'h8, 32'hA5000000, 32'h0, 0);
        tbl[7] = mk(1, 0, 3'd1, 32'h106, 32'h0, 32'h80017FFF, 2, 0, 0, 32'h104, 4'hF, 32'h0, 32'hFFFF8001, 0);
        tbl[8] = mk(1, 1, 3'd5, 32'h300, 32'h0, 32'h0000F00D, 1, 0, 0, 32'h300, 4'hF, 32'h0, 32'h0000F00D, 0);
        tbl[9] = mk(0, 1, 3'd1, 32'h201, 32'h1234, 32'h0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);

        #2 check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        foreach (tbl[i]) begin
            run_vec(tbl[i]);
            idle_cycle();
        end

        // Misaligned lw: checked instance refuses, unchecked instance reads the aligned word.
        @(negedge clk);
        valid_MEM = 1'b1; valid_b = 1'b1; mem_read_MEM = 1'b1; mem_write_MEM = 1'b0;
        funct3_MEM = 3'd2; ALU_out_MEM = 32'h102; data_mem_resp = 1'b0; ext_stall = 1'b0;
        #4 check_all("nochk.ref_side", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("nochk.read", {31'b0, rd_b}, 32'd1);
        chk("nochk.address", addr_b, 32'h100);
        chk("nochk.misalign", {31'b0, mis_b}, 32'd0);
        chk("nochk.stall", {31'b0, stall_b}, 32'd1);
        @(negedge clk);
        valid_MEM = 1'b0; data_mem_resp = 1'b1; data_mem_rdata = 32'h44332211;
        #4 check_all("nochk.idle_resp", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("nochk.load", load_b, 32'h00004433);
        chk("nochk.stall_resp", {31'b0, stall_b}, 32'd0);
        @(negedge clk);
        valid_b = 1'b0; data_mem_resp = 1'b0;
        #4 chk("nochk.read_after", {31'b0, rd_b}, 32'd0);

        // Reset in the middle of a request abandons it; a late resp is ignored.
        @(negedge clk);
        valid_MEM = 1'b1; mem_read_MEM = 1'b1; mem_write_MEM = 1'b0; funct3_MEM = 3'd2;
        ALU_out_MEM = 32'h100; data_mem_resp = 1'b0; ext_stall = 1'b0;
        #4 chk("rst.issue", {31'b0, rd_o}, 32'd1);
        @(negedge clk);
        #4 chk("rst.req_held", {31'b0, rd_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; valid_MEM = 1'b0;
        #1 check_all("rst.during", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; data_mem_resp = 1'b1; data_mem_rdata = 32'hCAFEF00D;
        #4 check_all("rst.late_resp", 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cycle();

        for (int n = 0; n < 300; n++) begin
            v.rd = 1'($urandom_range(0, 1));
            v.wr = ~v.rd | ($urandom_range(0, 9) == 0);
            if (v.rd) begin
                case ($urandom_range(0, 4))
                    0: v.f3 = 3'd0; 1: v.f3 = 3'd1; 2: v.f3 = 3'd2; 3: v.f3 = 3'd4; default: v.f3 = 3'd5;
                endcase
            end else begin
                v.f3 = 3'($urandom_range(0, 2));
            end
            v.addr  = $urandom;
            v.rs2   = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(1, 4);
            v.ext   = 1'($urandom_range(0, 1));
            v.hold  = $urandom_range(0, 2);
            run_vec(model(v));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
